// File: rtl/shift_right_sequencer_if.sv
// Request/result bundle for the shared right-shift sequencer.
// Two requesters (A, B) plus one result channel, all valid/ready.
interface shift_right_sequencer_if #(
    parameter int AMT_W = 3
);
    logic             a_valid;
    logic             a_ready;
    logic [3:0]       a_data;
    logic [AMT_W-1:0] a_amt;
    logic             b_valid;
    logic             b_ready;
    logic [3:0]       b_data;
    logic [AMT_W-1:0] b_amt;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;
    logic             res_id;

    modport slave (
        input  a_valid, a_data, a_amt,
        input  b_valid, b_data, b_amt,
        input  res_ready,
        output a_ready, b_ready,
        output res_valid, res_data, res_id
    );

    modport master (
        output a_valid, a_data, a_amt,
        output b_valid, b_data, b_amt,
        output res_ready,
        input  a_ready, b_ready,
        input  res_valid, res_data, res_id
    );
endinterface

// File: rtl/shift_right_sequencer.sv
// Shares one 4-bit/0..3 right-shift unit between two requesters,
// splitting long shifts into passes of at most three positions.
module shift_right_sequencer #(
    parameter int AMT_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    shift_right_sequencer_if.slave       bus,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       work;
    logic [AMT_W-1:0] rem;
    logic             id;
    logic             ptr;

    logic [1:0]       step;
    logic [3:0]       shifted;
    logic [AMT_W-1:0] rem_nx;
    logic             grant_a;
    logic             grant_b;
    logic             acc_a;
    logic             acc_b;

    // One pass through the shared shift unit, capped at three positions
    always_comb begin
        step    = (rem >= AMT_W'(3)) ? 2'd3 : rem[1:0];
        shifted = work >> step;
        rem_nx  = rem - AMT_W'(step);
    end

    // Arbitration and next-state; grants only exist while idle
    always_comb begin
        state_nx = state;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        unique case (state)
            IDLE: begin
                grant_a = !rst && (!bus.b_valid ||
                                   (bus.a_valid && !ptr));
                grant_b = !rst && bus.b_valid && !grant_a;
                if ((grant_a && bus.a_valid) || grant_b)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                if (rem_nx == '0)
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.res_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        acc_a = grant_a && bus.a_valid;
        acc_b = grant_b;
    end

    // State, working register, pass counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            rem   <= '0;
            id    <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc_a) begin
                work <= bus.a_data;
                rem  <= bus.a_amt;
                id   <= 1'b0;
                ptr  <= 1'b1;
            end else if (acc_b) begin
                work <= bus.b_data;
                rem  <= bus.b_amt;
                id   <= 1'b1;
                ptr  <= 1'b0;
            end else if (state == SHIFT) begin
                work <= shifted;
                rem  <= rem_nx;
            end
        end
    end

    // Result is held in registers for the whole DONE state
    always_comb begin
        bus.a_ready   = grant_a;
        bus.b_ready   = grant_b;
        bus.res_valid = (state == DONE);
        bus.res_data  = work;
        bus.res_id    = id;
        busy          = (state != IDLE);
    end

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Directed bench for shift_right_sequencer with a result scoreboard.
// Inputs change and outputs are sampled on the falling edge.
module tb_shift_right_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    shift_right_sequencer_if #(.AMT_W(3)) bus ();

    shift_right_sequencer #(.AMT_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int passes(logic [2:0] amt);
        return (amt == 0) ? 1 : (int'(amt) + 2) / 3;
    endfunction

    function automatic logic [4:0] model(logic id, logic [3:0] d,
                                         logic [2:0] amt);
        logic [3:0] r;
        r = d;
        for (int i = 0; i < int'(amt); i++)
            r = {1'b0, r[3:1]};
        return {id, r};
    endfunction

    // Called in the cycle after accept; exp_lat counts that cycle as 1
    task automatic wait_result(int exp_lat, int hold);
        int lat;
        logic [4:0] e;
        logic [3:0] first;
        lat = 1;
        while (!bus.res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (!bus.res_valid) return;
        first = bus.res_data;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", int'(bus.res_valid), 1);
            chk("hold_data", int'(bus.res_data), int'(first));
            chk("hold_a_ready", int'(bus.a_ready), 0);
            chk("hold_b_ready", int'(bus.b_ready), 0);
            chk("hold_busy", int'(busy), 1);
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("res_data", int'(bus.res_data), int'(e[3:0]));
            chk("res_id", int'(bus.res_id), int'(e[4]));
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
        chk("res_valid_drop", int'(bus.res_valid), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic single(logic id, logic [3:0] d, logic [2:0] amt,
                          int hold);
        int n;
        if (id) begin
            bus.b_valid = 1'b1;
            bus.b_data  = d;
            bus.b_amt   = amt;
        end else begin
            bus.a_valid = 1'b1;
            bus.a_data  = d;
            bus.a_amt   = amt;
        end
        #1;
        n = 0;
        while (!(id ? bus.b_ready : bus.a_ready) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", int'(id ? bus.b_ready : bus.a_ready), 1);
        sb.push_back(model(id, d, amt));
        @(negedge clk);
        if (id) bus.b_valid = 1'b0;
        else    bus.a_valid = 1'b0;
        #1;
        chk("busy_after_accept", int'(busy), 1);
        wait_result(passes(amt) + 1, hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rst_a_ready", int'(bus.a_ready), 0);
            chk("rst_res_valid", int'(bus.res_valid), 0);
            chk("rst_busy", int'(busy), 0);
        end
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.a_valid   = 1'b0;
        bus.a_data    = '0;
        bus.a_amt     = '0;
        bus.b_valid   = 1'b0;
        bus.b_data    = '0;
        bus.b_amt     = '0;
        bus.res_ready = 1'b0;

        // Reset with A already requesting
        bus.a_valid = 1'b1;
        bus.a_data  = 4'b1011;
        bus.a_amt   = 3'd2;
        do_reset();
        chk("rst_res_data", int'(bus.res_data), 0);
        chk("first_idle_a_ready", int'(bus.a_ready), 1);

        // A-only requests
        single(1'b0, 4'b1011, 3'd2, 0);
        single(1'b0, 4'b1000, 3'd3, 0);
        single(1'b0, 4'b1000, 3'd7, 0);
        single(1'b0, 4'b0110, 3'd0, 0);
        single(1'b0, 4'b1101, 3'd4, 0);

        // Contention, both held high from reset
        bus.a_valid = 1'b1;
        bus.a_data  = 4'b1111;
        bus.a_amt   = 3'd1;
        bus.b_valid = 1'b1;
        bus.b_data  = 4'b1111;
        bus.b_amt   = 3'd5;
        do_reset();
        chk("cont_a_first", int'(bus.a_ready), 1);
        chk("cont_b_wait", int'(bus.b_ready), 0);
        sb.push_back(model(1'b0, 4'b1111, 3'd1));
        @(negedge clk);
        bus.a_data = 4'b1010;
        bus.a_amt  = 3'd1;
        wait_result(2, 0);
        #1;
        chk("cont_b_second", int'(bus.b_ready), 1);
        chk("cont_a_wait", int'(bus.a_ready), 0);
        sb.push_back(model(1'b1, 4'b1111, 3'd5));
        @(negedge clk);
        bus.b_valid = 1'b0;
        wait_result(3, 0);
        #1;
        chk("cont_a_again", int'(bus.a_ready), 1);
        sb.push_back(model(1'b0, 4'b1010, 3'd1));
        @(negedge clk);
        bus.a_valid = 1'b0;
        wait_result(2, 0);

        // Backpressure on a B result
        single(1'b1, 4'b1100, 3'd1, 5);

        // Reset in the second SHIFT cycle of an amt-7 request
        bus.a_valid = 1'b1;
        bus.a_data  = 4'b1011;
        bus.a_amt   = 3'd7;
        #1;
        chk("mid_accept", int'(bus.a_ready), 1);
        @(negedge clk);
        bus.a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.res_valid) seen++;
            @(negedge clk);
        end
        chk("mid_no_result", seen, 0);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        chk("mid_ptr_a", int'(bus.a_ready), 1);
        chk("mid_ptr_b", int'(bus.b_ready), 0);
        bus.a_valid = 1'b0;
        single(1'b1, 4'b1101, 3'd2, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_sequencer.md
Name: shift_right_sequencer

Overview:
- Multi-cycle controller that shares one instance of the existing 4-bit combinational right-shift unit (4-bit operand, 2-bit amount 0..3) between two requesters, A and B.
- Accepts shift-right requests of 0..(2^AMT_W-1) positions and decomposes each into successive passes of at most 3 positions through the unit.
- Round-robin arbitration between A and B; one result interface with a valid/ready handshake.
- Sits between the ALU operand/control logic and the shift datapath.

Parameters:
- AMT_W, 3, width of requested shift amount; max request = 2^AMT_W-1 positions.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  requester A has a request; held with a_data/a_amt until accepted.
- a_ready  out  1  A accepted this cycle when a_valid && a_ready.
- a_data  in  4  operand A.
- a_amt  in  AMT_W  shift amount A.
- b_valid  in  1  same as a_valid, for B.
- b_ready  out  1  same as a_ready, for B.
- b_data  in  4  operand B.
- b_amt  in  AMT_W  shift amount B.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result when res_valid && res_ready.
- res_data  out  4  shifted operand.
- res_id  out  1  0 = result for A, 1 = result for B.
- busy  out  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: a_ready=0, b_ready=0, res_valid=0, res_data=0, res_id=0, busy=0, priority pointer = A, remaining count = 0.
- a_ready and b_ready are combinational and asserted only in IDLE.
  - Only one is high at a time: the requester with valid, with the pointer choosing when both are valid.
  - Ready never depends on valid of the same requester when that requester is alone.
- Arbitration:
  - Both valid: grant goes to the pointer side.
  - Only one valid: that one is granted.
  - After each grant, the pointer moves to the other requester.
- Accept (IDLE, handshake true):
  - Capture data into the working register, amt into the remaining counter, and the id.
  - Next state is SHIFT.
- SHIFT, each cycle:
  - step = (remaining >= 3) ? 3 : remaining[1:0].
  - working <= unit(working, step); remaining <= remaining - step.
  - If remaining - step == 0, go to DONE; otherwise stay in SHIFT.
  - An amount of 0 takes exactly one SHIFT cycle with step 0, so the data passes through unchanged.
- Pass count: n = max(1, ceil(amt/3)). For AMT_W=3, amt 7 takes steps 3, 3, 1.
- There is no early termination when the working register reaches zero; the pass count depends only on amt.
- Latency: accepted in cycle k, res_valid is high from cycle k+n+1.
- DONE:
  - res_valid=1; res_data and res_id are registered and stable while res_valid is high.
  - When res_ready=1, go to IDLE in the next cycle; res_valid is 0 in that cycle.
  - While res_ready=0, hold indefinitely with outputs unchanged.
- No new request is accepted in SHIFT or DONE, so the minimum spacing between accepts is n+2 cycles.
- Requests that arrive while busy wait; requesters keep valid high.
- rst has priority over all events in every state, including mid-SHIFT and DONE.
  - An in-flight operation is discarded with no result.
  - The pointer returns to A.
- res_data is always 4 bits; bits shifted in are 0 (logical shift).

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=1 → a_ready=0, res_valid=0, busy=0 during reset; after release, a_ready=1 in the first IDLE cycle.
- A only, data 1011, amt 2, accepted in cycle k → res_valid at k+2, res_data=0010, res_id=0, busy high for cycles k+1..k+2.
- A only, data 1000, amt 3 → result 0001 at k+2; amt 7 → steps 3,3,1, result 0000 at k+4; amt 0, data 0110 → 0110 at k+2.
- Contention: after reset, a_valid and b_valid both held high; A = (1111, 1), B = (1111, 5).
  - A is granted first → 0111, id 0.
  - B is granted on the next IDLE → 0000, id 1.
  - A request re-raised immediately is granted after B, giving alternation.
- Backpressure: B data 1100, amt 1, res_ready held low 5 cycles → res_valid=1 and res_data=0110 stable for all 5 cycles; b_ready and a_ready stay 0; IDLE is entered one cycle after res_ready=1.
- Reset mid-operation: A amt 7 accepted, rst asserted in the second SHIFT cycle → no res_valid ever for that request; state returns to IDLE and pointer = A; a fresh B-only request completes correctly.
